// File: rtl/process_scheduler_pkg.sv
// Shared types and defaults for the chip process scheduler.
// Holds the FSM state enum and a helper that sizes the process index.
package chip_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  localparam int DEFAULT_PROCESSES  = 4;
  localparam int DEFAULT_STEP_WIDTH = 32;

  // Index width never drops below one bit, even for a single process.
  function automatic int idx_width(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/process_scheduler_if.sv
// Control/observe bundle between the chip top level and the process scheduler.
// start is a level, not a valid/ready handshake: it is acted on only while the
// scheduler sits in IDLE or DONE, and ignored otherwise; no ready is returned.
interface process_scheduler_if #(
    parameter int PROCESSES  = chip_pkg::DEFAULT_PROCESSES,
    parameter int STEP_WIDTH = chip_pkg::DEFAULT_STEP_WIDTH,
    parameter int IDX_WIDTH  = chip_pkg::idx_width(PROCESSES)
);

    logic                   start;
    logic [STEP_WIDTH-1:0]  maxSteps;
    logic [PROCESSES-1:0]   stopped;

    logic                   initAll;
    logic [PROCESSES-1:0]   grant;
    logic [IDX_WIDTH-1:0]   current;
    logic                   stepDone;
    logic [STEP_WIDTH-1:0]  step;
    logic                   running;
    logic                   done;
    logic                   timeout;
    chip_pkg::sched_state_t state;

    modport master (
        output start, maxSteps, stopped,
        input  initAll, grant, current, stepDone, step, running, done, timeout, state
    );

    modport slave (
        input  start, maxSteps, stopped,
        output initAll, grant, current, stepDone, step, running, done, timeout, state
    );

endinterface

// File: rtl/process_scheduler_next_live_finder.sv
// Masked priority encoder: lowest live process at or after the search origin,
// plus whether any live process remains above the one it picked.
module next_live_finder #(
    parameter int PROCESSES = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [PROCESSES-1:0] stopped,
    input  logic [IDX_WIDTH-1:0] current,
    input  logic                 atBoundary,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] index,
    output logic                 isLast
);

    always_comb begin
        found  = 1'b0;
        index  = '0;
        isLast = 1'b1;
        // Scan downward so the lowest eligible index is the one left standing.
        for (int i = PROCESSES - 1; i >= 0; i--) begin
            if (!stopped[i] && (atBoundary || (IDX_WIDTH'(i) > current))) begin
                found = 1'b1;
                index = IDX_WIDTH'(i);
            end
        end
        for (int j = 0; j < PROCESSES; j++) begin
            if (!stopped[j] && (IDX_WIDTH'(j) > index)) begin
                isLast = 1'b0;
            end
        end
    end

endmodule

// File: rtl/process_scheduler.sv
// Steps every live process once per step in ascending index order, one grant per
// cycle, and halts when all processes stop or the step budget runs out.
module process_scheduler
    import chip_pkg::*;
#(
    parameter int PROCESSES  = DEFAULT_PROCESSES,
    parameter int STEP_WIDTH = DEFAULT_STEP_WIDTH,
    parameter int IDX_WIDTH  = idx_width(PROCESSES)
) (
    input logic               clock,
    input logic               reset_n,
    process_scheduler_if.slave bus
);

    sched_state_t           state_q, state_d;
    logic [PROCESSES-1:0]   grant_q, grant_d;
    logic [IDX_WIDTH-1:0]   current_q, current_d;
    logic                   step_done_q, step_done_d;
    logic                   init_q, init_d;
    logic [STEP_WIDTH-1:0]  step_q, step_d;
    logic [STEP_WIDTH-1:0]  max_q, max_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic                   running_q, running_d;

    logic                   boundary;
    logic                   found;
    logic [IDX_WIDTH-1:0]   found_idx;
    logic                   is_last;
    logic [STEP_WIDTH-1:0]  step_sat_inc;

    // Outputs are registered, so every decision here picks next cycle's grant.
    // The cycle after INIT or after a stepDone is where a new step is decided.
    assign boundary     = (state_q == INIT) || step_done_q;
    assign step_sat_inc = (&step_q) ? step_q : step_q + 1'b1;

    next_live_finder #(
        .PROCESSES (PROCESSES),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_finder (
        .stopped    (bus.stopped),
        .current    (current_q),
        .atBoundary (boundary),
        .found      (found),
        .index      (found_idx),
        .isLast     (is_last)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = '0;
        current_d   = current_q;
        step_done_d = 1'b0;
        init_d      = 1'b0;
        step_d      = step_q;
        max_d       = max_q;
        done_d      = done_q;
        timeout_d   = timeout_q;

        if ((state_q == RUN) && step_done_q) begin
            step_d = step_sat_inc;
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = INIT;
                    init_d    = 1'b1;
                    step_d    = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    max_d     = bus.maxSteps;
                end
            end
            INIT, RUN: begin
                state_d = RUN;
                // step_d already includes the increment owed by a stepDone this cycle.
                if (boundary && (&bus.stopped)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (boundary && (step_d == max_q)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else if (found) begin
                    grant_d[found_idx] = 1'b1;
                    current_d          = found_idx;
                    step_done_d        = is_last;
                end else begin
                    // Every higher process stopped mid-step: close the step without a grant.
                    step_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        running_d = (state_d == INIT) || (state_d == RUN);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            current_q   <= '0;
            step_done_q <= 1'b0;
            init_q      <= 1'b0;
            step_q      <= '0;
            max_q       <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            current_q   <= current_d;
            step_done_q <= step_done_d;
            init_q      <= init_d;
            step_q      <= step_d;
            max_q       <= max_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            running_q   <= running_d;
        end
    end

    assign bus.initAll  = init_q;
    assign bus.grant    = grant_q;
    assign bus.current  = current_q;
    assign bus.stepDone = step_done_q;
    assign bus.step     = step_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.timeout  = timeout_q;
    assign bus.state    = state_q;

endmodule
